// File: rtl/tm1638_top.sv
// Write-only TM1638 refresh driver: streams command/data frames built from
// four synchronized board switches over the CLK/STB/DIO serial interface.
module tm1638_top #(
    parameter int unsigned CLK_DIV   = 50,
    parameter logic [2:0]  BRIGHT    = 3'd7,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic SWITCH1,
    input  logic SWITCH2,
    input  logic SWITCH3,
    input  logic SWITCH4,
    output logic out_clk_1,
    output logic strobe,
    output logic dio
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_END,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_snap;
    logic [1:0]    r_frame;
    logic [4:0]    r_byte;
    logic [2:0]    r_bit;
    logic          r_phase;
    logic          r_clk;
    logic          r_stb;
    logic          r_dio;

    logic          w_tick;
    logic          w_last_byte;
    logic [3:0]    w_addr;
    logic [7:0]    w_byte;

    assign w_tick      = (r_cnt == CW'(CLK_DIV - 1));
    assign w_last_byte = (r_frame == 2'd1) ? (r_byte == 5'd16) : (r_byte == 5'd0);
    assign out_clk_1   = r_clk;
    assign strobe      = r_stb;
    assign dio         = r_dio;

    // Byte currently being shifted: F1 command, F2 address + display RAM image, F3 display control.
    always_comb begin
        w_byte = 8'h00;
        w_addr = 4'(r_byte - 5'd1);
        case (r_frame)
            2'd0: w_byte = 8'h40;
            2'd1: begin
                if (r_byte == 5'd0) begin
                    w_byte = 8'hC0;
                end else if (!w_addr[3] && r_snap[w_addr[2:1]]) begin
                    if (w_addr[0]) begin
                        w_byte = 8'h01;
                    end else begin
                        case (w_addr[2:1])
                            2'd0:    w_byte = 8'h06;
                            2'd1:    w_byte = 8'h5B;
                            2'd2:    w_byte = 8'h4F;
                            default: w_byte = 8'h66;
                        endcase
                    end
                end
            end
            default: w_byte = {5'b10001, BRIGHT};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_snap  <= '0;
            r_frame <= 2'd0;
            r_byte  <= '0;
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_clk   <= 1'b1;
            r_stb   <= 1'b1;
            r_dio   <= 1'b1;
        end else begin
            r_sync1 <= {SWITCH4, SWITCH3, SWITCH2, SWITCH1};
            r_sync2 <= r_sync1;
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                case (r_state)
                    S_IDLE, S_GAP: begin
                        if (r_gap == GW'(GAP_TICKS - 1)) begin
                            r_gap   <= '0;
                            r_stb   <= 1'b0;
                            r_byte  <= '0;
                            r_bit   <= '0;
                            r_state <= S_START;
                            if (r_frame == 2'd1) begin
                                r_snap <= r_sync2;
                            end
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    S_START: begin
                        r_clk   <= 1'b0;
                        r_dio   <= w_byte[r_bit];
                        r_phase <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        if (!r_phase) begin
                            r_clk   <= 1'b0;
                            r_dio   <= w_byte[r_bit];
                            r_phase <= 1'b1;
                        end else begin
                            r_clk   <= 1'b1;
                            r_phase <= 1'b0;
                            if (r_bit == 3'd7) begin
                                r_bit <= '0;
                                if (w_last_byte) begin
                                    r_state <= S_END;
                                end else begin
                                    r_byte <= r_byte + 5'd1;
                                end
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                    end
                    S_END: begin
                        // One trailing tick with CLK high before STB is released.
                        if (r_gap == '0) begin
                            r_gap <= GW'(1);
                        end else begin
                            r_gap   <= '0;
                            r_stb   <= 1'b1;
                            r_dio   <= 1'b1;
                            r_frame <= (r_frame == 2'd2) ? 2'd0 : r_frame + 2'd1;
                            r_state <= S_GAP;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_top.sv
// Scoreboard bench for tm1638_top: expected bytes/frame lengths are queued by
// the stimulus; a serial monitor decodes DIO on CLK rises and checks them.
module tb_tm1638_top;

    localparam int unsigned DIV   = 10;
    localparam int unsigned GAP   = 4;
    localparam longint      TCLK  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw1 = 1'b1;
    logic sw2 = 1'b1;
    logic sw3 = 1'b1;
    logic sw4 = 1'b1;
    logic out_clk_1;
    logic strobe;
    logic dio;

    tm1638_top #(.CLK_DIV(DIV), .BRIGHT(3'd7), .GAP_TICKS(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .SWITCH1   (sw1),
        .SWITCH2   (sw2),
        .SWITCH3   (sw3),
        .SWITCH4   (sw4),
        .out_clk_1 (out_clk_1),
        .strobe    (strobe),
        .dio       (dio)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         errors      = 0;
    int         frames_done = 0;
    logic [7:0] exp_bytes[$];
    int         exp_len[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Expected frames of one refresh cycle for switch pattern sw (bit0 = SWITCH1).
    task automatic push_cycle(input logic [3:0] sw);
        logic [7:0] seg [4];
        seg = '{8'h06, 8'h5B, 8'h4F, 8'h66};
        exp_bytes.push_back(8'h40);
        exp_len.push_back(18);
        exp_bytes.push_back(8'hC0);
        for (int k = 0; k < 4; k++) begin
            exp_bytes.push_back(sw[k] ? seg[k] : 8'h00);
            exp_bytes.push_back(sw[k] ? 8'h01 : 8'h00);
        end
        for (int k = 0; k < 8; k++) exp_bytes.push_back(8'h00);
        exp_len.push_back(274);
        exp_bytes.push_back(8'h8F);
        exp_len.push_back(18);
    endtask

    // Serial monitor / scoreboard.
    logic       prev_ck  = 1'b1;
    logic       prev_stb = 1'b1;
    logic [7:0] sh       = 8'h00;
    int         nbits    = 0;
    longint     t_fall   = 0;
    longint     t_rise   = 0;
    bit         have_rise = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_ck   = 1'b1;
            prev_stb  = 1'b1;
            nbits     = 0;
            have_rise = 1'b0;
        end else begin
            if (prev_stb && !strobe) begin
                if (have_rise) check("gap_ns", longint'($time) - t_rise, longint'(GAP * DIV) * TCLK);
                t_fall = longint'($time);
                nbits  = 0;
            end
            if (!strobe && out_clk_1 && !prev_ck) begin
                sh = {dio, sh[7:1]};
                nbits++;
                if (nbits % 8 == 0) begin
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h, required none", sh);
                    end else begin
                        check("frame_byte", sh, exp_bytes.pop_front());
                    end
                end
            end
            if (!prev_stb && strobe) begin
                if (exp_len.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0d bits, required none", nbits);
                end else begin
                    check("frame_ticks", (longint'($time) - t_fall) / (longint'(DIV) * TCLK), exp_len.pop_front());
                end
                check("frame_bits_mod8", nbits % 8, 0);
                check("clk_high_after_frame", out_clk_1, 1);
                check("dio_high_after_frame", dio, 1);
                t_rise    = longint'($time);
                have_rise = 1'b1;
                frames_done++;
            end
            prev_ck  = out_clk_1;
            prev_stb = strobe;
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames_done < target) check("timeout_frames", frames_done, target);
    endtask

    task automatic wait_strobe_low(input int budget);
        int n = 0;
        while (strobe !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (strobe !== 1'b0) check("timeout_strobe_low", strobe, 0);
    endtask

    task automatic release_and_measure();
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        while (n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (strobe == 1'b0) break;
        end
        check("first_fall_clks", n, GAP * DIV);
    endtask

    initial begin
        int   bad   = 0;
        int   edges = 0;
        logic pc    = 1'b1;

        #1 rst = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (out_clk_1 !== 1'b1 || strobe !== 1'b1 || dio !== 1'b1) bad++;
            if (out_clk_1 !== pc) edges++;
            pc = out_clk_1;
        end
        check("reset_bad_samples", bad, 0);
        check("reset_clk_edges", edges, 0);
        check("reset_clk", out_clk_1, 1);
        check("reset_stb", strobe, 1);
        check("reset_dio", dio, 1);

        // Cycle 1 all on, cycle 2 with SWITCH2 off (toggled back mid-F2), cycle 3 all on again.
        push_cycle(4'b1111);
        push_cycle(4'b1101);
        push_cycle(4'b1111);
        release_and_measure();

        wait_frames(3, 10000);
        sw2 = 1'b0;
        wait_frames(4, 10000);
        wait_strobe_low(2000);
        repeat (100) @(negedge clk);
        sw2 = 1'b1;
        wait_frames(9, 20000);

        // Cycle 4: reset during the F2 data bytes.
        push_cycle(4'b1111);
        wait_frames(10, 10000);
        wait_strobe_low(2000);
        repeat (600) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_clk", out_clk_1, 1);
        check("midreset_stb", strobe, 1);
        check("midreset_dio", dio, 1);
        exp_bytes.delete();
        exp_len.delete();
        repeat (20) @(negedge clk);

        exp_bytes.push_back(8'h40);
        exp_len.push_back(18);
        release_and_measure();
        wait_frames(11, 10000);
        check("leftover_bytes", exp_bytes.size(), 0);
        check("leftover_frames", exp_len.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
